eff_drive: RTL and testbench

- Parametrised successor to the fixed gain-of-2 / ±200 hard clipper.
- Provides a runtime-programmable gain, a programmable threshold and four waveshaping modes: hard, soft, fold and asymmetric.
- Bypass path is latency-matched, so toggling `en` never shifts sample timing.
- Config and `en` changes are glitch-free (applied only at sample boundaries); a held clip-indicator output drives a front-panel LED.
- Sits in the effect chain between the ADC sample stream and downstream effects; same `data`/`vld` streaming interface as the other `eff_*` blocks.

---
 rtl/sample_pkg.sv | 14 +
 rtl/eff_drive_shape.sv | 83 ++++++++
 rtl/eff_drive.sv | 205 ++++++++++++++++++++
 tb/tb_eff_drive.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared types and constants for the eff_* sample-stream effect blocks.
package sample_pkg;

    typedef enum logic [1:0] {
        DRV_HARD = 2'd0,
        DRV_SOFT = 2'd1,
        DRV_FOLD = 2'd2,
        DRV_ASYM = 2'd3
    } drive_mode_e;

    localparam int GAIN_FRAC  = 4;
    localparam int UNITY_GAIN = 16;

endpackage

// File: rtl/eff_drive_shape.sv
// Combinational waveshaper: hard / soft / fold / asymmetric limiting of the gained sample.
module eff_drive_shape
    import sample_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int P_WIDTH    = 33
) (
    input  logic signed [P_WIDTH-1:0]    p,
    input  logic        [DATA_WIDTH-2:0] thresh,
    input  drive_mode_e                  mode,
    output logic signed [P_WIDTH+1:0]    y,
    output logic                         clip
);

    localparam int E_WIDTH = P_WIDTH + 2;

    logic signed [E_WIDTH-1:0] pe;
    logic signed [E_WIDTH-1:0] t_hi;
    logic signed [E_WIDTH-1:0] t_neg;
    logic signed [E_WIDTH-1:0] t_half;
    logic signed [E_WIDTH-1:0] mag;
    logic signed [E_WIDTH-1:0] f;

    assign pe     = E_WIDTH'(p);
    assign t_hi   = $signed(E_WIDTH'(thresh));
    // A full-scale threshold opens the negative limit to the most negative code so
    // the default configuration is fully transparent.
    assign t_neg  = (thresh == '1) ? t_hi + E_WIDTH'(1) : t_hi;
    assign t_half = t_hi >>> 1;
    assign mag    = pe[E_WIDTH-1] ? -pe : pe;

    always_comb begin
        y    = pe;
        clip = 1'b0;
        f    = pe;
        case (mode)
            DRV_HARD: begin
                if (pe > t_hi) begin
                    y    = t_hi;
                    clip = 1'b1;
                end else if (pe < -t_neg) begin
                    y    = -t_neg;
                    clip = 1'b1;
                end
            end
            DRV_SOFT: begin
                if (!pe[E_WIDTH-1] && pe > t_hi) begin
                    y    = t_hi + ((pe - t_hi) >>> 2);
                    clip = 1'b1;
                end else if (pe[E_WIDTH-1] && mag > t_neg) begin
                    y    = -(t_neg + ((mag - t_neg) >>> 2));
                    clip = 1'b1;
                end
            end
            DRV_FOLD: begin
                if (pe > t_hi) begin
                    f    = (t_hi <<< 1) - pe;
                    clip = 1'b1;
                end else if (pe < -t_neg) begin
                    f    = -(t_neg <<< 1) - pe;
                    clip = 1'b1;
                end
                if (f > t_hi)
                    y = t_hi;
                else if (f < -t_neg)
                    y = -t_neg;
                else
                    y = f;
            end
            DRV_ASYM: begin
                if (pe > t_hi) begin
                    y    = t_hi;
                    clip = 1'b1;
                end else if (pe < -t_half) begin
                    y    = -t_half;
                    clip = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/eff_drive.sv
// Overdrive effect: programmable gain, four shaping modes, latency-matched bypass and
// a held clip indicator. Four-cycle pipeline, config applied at sample boundaries.
module eff_drive
    import sample_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int GAIN_WIDTH   = 8,
    parameter int HOLD_SAMPLES = 4800
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [GAIN_WIDTH-1:0]        gain,
    input  logic [DATA_WIDTH-2:0]        thresh,
    input  logic                         cfg_upd,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         vld_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         vld_o,
    output logic                         clip_o
);

    localparam int P_WIDTH   = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int E_WIDTH   = P_WIDTH + 2;
    localparam int CNT_WIDTH = $clog2(HOLD_SAMPLES + 1);

    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [E_WIDTH-1:0] v);
        logic [E_WIDTH-DATA_WIDTH:0] top;
        top = v[E_WIDTH-1:DATA_WIDTH-1];
        if (top == '0 || top == '1)
            return {1'b0, v[DATA_WIDTH-1:0]};
        else if (v[E_WIDTH-1])
            return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

    drive_mode_e           act_mode, pend_mode, nxt_mode;
    logic [GAIN_WIDTH-1:0] act_gain, pend_gain, nxt_gain;
    logic [DATA_WIDTH-2:0] act_thresh, pend_thresh, nxt_thresh;
    logic                  act_en, pend;

    // A strobe in the same cycle as a sample wins over anything still pending.
    always_comb begin
        nxt_mode   = act_mode;
        nxt_gain   = act_gain;
        nxt_thresh = act_thresh;
        if (cfg_upd) begin
            nxt_mode   = drive_mode_e'(mode);
            nxt_gain   = gain;
            nxt_thresh = thresh;
        end else if (pend) begin
            nxt_mode   = pend_mode;
            nxt_gain   = pend_gain;
            nxt_thresh = pend_thresh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_mode    <= DRV_HARD;
            act_gain    <= GAIN_WIDTH'(UNITY_GAIN);
            act_thresh  <= '1;
            act_en      <= 1'b0;
            pend        <= 1'b0;
            pend_mode   <= DRV_HARD;
            pend_gain   <= GAIN_WIDTH'(UNITY_GAIN);
            pend_thresh <= '1;
        end else if (vld_i) begin
            act_mode   <= nxt_mode;
            act_gain   <= nxt_gain;
            act_thresh <= nxt_thresh;
            act_en     <= en;
            pend       <= 1'b0;
        end else if (cfg_upd) begin
            pend_mode   <= drive_mode_e'(mode);
            pend_gain   <= gain;
            pend_thresh <= thresh;
            pend        <= 1'b1;
        end
    end

    // S1: sample plus the config it will be processed with
    logic signed [DATA_WIDTH-1:0] data_p0;
    drive_mode_e                  mode_p0;
    logic [GAIN_WIDTH-1:0]        gain_p0;
    logic [DATA_WIDTH-2:0]        thresh_p0;
    logic                         en_p0, vld_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            data_p0   <= '0;
            mode_p0   <= DRV_HARD;
            gain_p0   <= GAIN_WIDTH'(UNITY_GAIN);
            thresh_p0 <= '1;
            en_p0     <= 1'b0;
        end else begin
            vld_p0    <= vld_i;
            data_p0   <= data_i;
            mode_p0   <= nxt_mode;
            gain_p0   <= nxt_gain;
            thresh_p0 <= nxt_thresh;
            en_p0     <= vld_i ? en : act_en;
        end
    end

    // S2: gain multiply, floor back to integer scale
    logic signed [P_WIDTH-1:0] x_ext, g_ext, prod, p_p1;
    logic signed [DATA_WIDTH-1:0] data_p1;
    drive_mode_e                  mode_p1;
    logic [DATA_WIDTH-2:0]        thresh_p1;
    logic                         en_p1, vld_p1;

    assign x_ext = P_WIDTH'(data_p0);
    assign g_ext = P_WIDTH'($signed({1'b0, gain_p0}));
    assign prod  = x_ext * g_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            p_p1      <= '0;
            data_p1   <= '0;
            mode_p1   <= DRV_HARD;
            thresh_p1 <= '1;
            en_p1     <= 1'b0;
        end else begin
            vld_p1    <= vld_p0;
            p_p1      <= prod >>> GAIN_FRAC;
            data_p1   <= data_p0;
            mode_p1   <= mode_p0;
            thresh_p1 <= thresh_p0;
            en_p1     <= en_p0;
        end
    end

    // S3: waveshaping
    logic signed [E_WIDTH-1:0]    shaped, y_p2;
    logic                         shape_clip, clip_p2;
    logic signed [DATA_WIDTH-1:0] data_p2;
    logic                         en_p2, vld_p2;

    eff_drive_shape #(
        .DATA_WIDTH (DATA_WIDTH),
        .P_WIDTH    (P_WIDTH)
    ) u_shape (
        .p      (p_p1),
        .thresh (thresh_p1),
        .mode   (mode_p1),
        .y      (shaped),
        .clip   (shape_clip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            y_p2    <= '0;
            clip_p2 <= 1'b0;
            data_p2 <= '0;
            en_p2   <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            y_p2    <= shaped;
            clip_p2 <= shape_clip;
            data_p2 <= data_p1;
            en_p2   <= en_p1;
        end
    end

    // S4: saturate, bypass select, clip hold
    logic [DATA_WIDTH:0]          sat;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_clip;
    logic [CNT_WIDTH-1:0]         hold_cnt;

    assign sat = saturate(y_p2);

    always_comb begin
        out_data = en_p2 ? $signed(sat[DATA_WIDTH-1:0]) : data_p2;
        out_clip = en_p2 & (clip_p2 | sat[DATA_WIDTH]);
    end

    // clip_o reflects the count before this sample's decrement, so it stays high
    // for exactly HOLD_SAMPLES samples after the last clipped one.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_o    <= 1'b0;
            data_o   <= '0;
            clip_o   <= 1'b0;
            hold_cnt <= '0;
        end else begin
            vld_o <= vld_p2;
            if (vld_p2) begin
                data_o <= out_data;
                clip_o <= out_clip || (hold_cnt != '0);
                if (out_clip)
                    hold_cnt <= CNT_WIDTH'(HOLD_SAMPLES);
                else if (hold_cnt != '0)
                    hold_cnt <= hold_cnt - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_eff_drive.sv
// Directed bench for eff_drive at 16-bit samples with an 8-sample clip hold.
module tb_eff_drive;
    import sample_pkg::*;

    localparam int DW = 16;
    localparam int GW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic [1:0]           mode = 2'd0;
    logic [GW-1:0]        gain = 8'd16;
    logic [DW-2:0]        thresh = 15'h7fff;
    logic                 cfg_upd = 1'b0;
    logic signed [DW-1:0] data_i = '0;
    logic                 vld_i = 1'b0;
    logic signed [DW-1:0] data_o;
    logic                 vld_o;
    logic                 clip_o;

    int errors = 0;
    int checks = 0;

    eff_drive #(
        .DATA_WIDTH   (DW),
        .GAIN_WIDTH   (GW),
        .HOLD_SAMPLES (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .gain    (gain),
        .thresh  (thresh),
        .cfg_upd (cfg_upd),
        .data_i  (data_i),
        .vld_i   (vld_i),
        .data_o  (data_o),
        .vld_o   (vld_o),
        .clip_o  (clip_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; vld_i = 1'b0; cfg_upd = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] m, input logic [GW-1:0] g, input logic [DW-2:0] t);
        @(negedge clk);
        mode = m; gain = g; thresh = t; cfg_upd = 1'b1;
        @(negedge clk);
        cfg_upd = 1'b0;
    endtask

    // upd: 0 none, 1 strobe in the cycle after the sample, 2 strobe with the sample
    task automatic xfer(input logic signed [DW-1:0] x, input int upd, input logic en_s,
                        input logic en_after, output logic signed [DW-1:0] y,
                        output logic c, output logic lat_ok);
        logic v3;
        @(negedge clk);
        data_i = x; vld_i = 1'b1; en = en_s; cfg_upd = (upd == 2);
        @(negedge clk);
        vld_i = 1'b0; en = en_after; cfg_upd = (upd == 1);
        @(negedge clk);
        cfg_upd = 1'b0;
        @(posedge clk); #1;
        v3 = vld_o;
        @(posedge clk); #1;
        lat_ok = !v3 && vld_o;
        y = data_o;
        c = clip_o;
    endtask

    logic signed [DW-1:0] y;
    logic c, lat;
    logic seen;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", vld_o, 0);
        check("rst_data", data_o, 0);
        check("rst_clip", clip_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // defaults are transparent
        xfer(16'sd1000, 0, 1, 1, y, c, lat);
        check("def_1000", y, 1000);
        check("def_lat", lat, 1);
        check("def_clip", c, 0);
        xfer(-16'sd32768, 0, 1, 1, y, c, lat);
        check("def_min", y, -32768);
        check("def_min_clip", c, 0);
        repeat (2) @(negedge clk);
        check("hold_data", data_o, -32768);
        check("hold_vld", vld_o, 0);

        // hard clip and clip hold
        cfg(DRV_HARD, 8'd32, 15'd200);
        xfer(16'sd50, 0, 1, 1, y, c, lat);
        check("hard_50", y, 100);
        check("hard_50_clip", c, 0);
        xfer(16'sd150, 0, 1, 1, y, c, lat);
        check("hard_150", y, 200);
        check("hard_150_clip", c, 1);
        xfer(-16'sd150, 0, 1, 1, y, c, lat);
        check("hard_m150", y, -200);
        for (int i = 1; i <= 9; i++) begin
            xfer(16'sd0, 0, 1, 1, y, c, lat);
            check($sformatf("hold_%0d", i), c, (i <= 8) ? 1 : 0);
        end

        // modes; soft config arrives with the sample itself
        mode = DRV_SOFT; gain = 8'd16; thresh = 15'd1000;
        xfer(16'sd2000, 2, 1, 1, y, c, lat);
        check("soft_2000", y, 1250);
        xfer(-16'sd3000, 0, 1, 1, y, c, lat);
        check("soft_m3000", y, -1500);
        cfg(DRV_FOLD, 8'd16, 15'd1000);
        xfer(16'sd2000, 0, 1, 1, y, c, lat);
        check("fold_2000", y, 0);
        xfer(16'sd5000, 0, 1, 1, y, c, lat);
        check("fold_5000", y, -1000);
        cfg(DRV_ASYM, 8'd16, 15'd1000);
        xfer(16'sd2000, 0, 1, 1, y, c, lat);
        check("asym_2000", y, 1000);
        xfer(-16'sd2000, 0, 1, 1, y, c, lat);
        check("asym_m2000", y, -500);

        // zero threshold
        cfg(DRV_HARD, 8'd16, 15'd0);
        xfer(16'sd2000, 0, 1, 1, y, c, lat);
        check("t0_hard", y, 0);
        cfg(DRV_SOFT, 8'd16, 15'd0);
        xfer(16'sd2000, 0, 1, 1, y, c, lat);
        check("t0_soft", y, 500);
        xfer(-16'sd2000, 0, 1, 1, y, c, lat);
        check("t0_soft_neg", y, -500);
        cfg(DRV_FOLD, 8'd16, 15'd0);
        xfer(-16'sd3000, 0, 1, 1, y, c, lat);
        check("t0_fold", y, 0);
        cfg(DRV_ASYM, 8'd16, 15'd0);
        xfer(-16'sd2000, 0, 1, 1, y, c, lat);
        check("t0_asym", y, 0);

        // a second strobe overwrites the pending values
        cfg(DRV_HARD, 8'd48, 15'h7fff);
        cfg(DRV_HARD, 8'd16, 15'h7fff);
        xfer(16'sd100, 0, 1, 1, y, c, lat);
        check("overwrite", y, 100);

        // saturation
        do_reset();
        cfg(DRV_HARD, 8'd255, 15'h7fff);
        xfer(16'sd30000, 0, 1, 1, y, c, lat);
        check("sat_pos", y, 32767);
        check("sat_pos_clip", c, 1);
        xfer(-16'sd30000, 0, 1, 1, y, c, lat);
        check("sat_neg", y, -32768);

        // glitch-free config and en changes on a sparse ramp
        do_reset();
        xfer(16'sd100, 0, 1, 1, y, c, lat);
        check("ramp_100", y, 100);
        gain = 8'd32;
        xfer(16'sd200, 1, 1, 1, y, c, lat);
        check("ramp_200_old_gain", y, 200);
        xfer(16'sd300, 0, 1, 1, y, c, lat);
        check("ramp_300_new_gain", y, 600);
        xfer(16'sd400, 0, 1, 0, y, c, lat);
        check("ramp_400_en_inflight", y, 800);
        xfer(16'sd500, 0, 0, 0, y, c, lat);
        check("ramp_500_bypass", y, 500);
        check("ramp_500_lat", lat, 1);
        check("ramp_500_clip", c, 0);
        xfer(-16'sd32768, 0, 0, 1, y, c, lat);
        check("bypass_min", y, -32768);
        xfer(16'sd600, 0, 1, 1, y, c, lat);
        check("ramp_600_en", y, 1200);
        check("ramp_600_lat", lat, 1);

        // reset with samples in flight
        xfer(16'sd30000, 0, 1, 1, y, c, lat);
        check("pre_rst_sat", y, 32767);
        check("pre_rst_clip", c, 1);
        @(negedge clk);
        data_i = 16'sd100; vld_i = 1'b1; en = 1'b1;
        @(negedge clk);
        data_i = 16'sd200;
        @(negedge clk);
        data_i = 16'sd300;
        @(negedge clk);
        vld_i = 1'b0; rst = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (vld_o) seen = 1'b1;
        end
        check("flush_no_vld", seen, 0);
        check("flush_clip", clip_o, 0);
        xfer(16'sd1000, 0, 1, 1, y, c, lat);
        check("flush_default_gain", y, 1000);

        // zero gain
        cfg(DRV_HARD, 8'd0, 15'd100);
        xfer(16'sd12345, 0, 1, 1, y, c, lat);
        check("gain0", y, 0);
        check("gain0_clip", c, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
